// File: rtl/dma_2d_pkg.sv
// Shared constants, FSM state and command type for the 2D burst command generator.
package dma_2d_pkg;

    localparam int BYTES_PER_BEAT = 4;
    localparam int BOUNDARY_4K    = 4096;
    localparam int AXI_LEN_W      = 8;
    localparam int CMD_ADDR_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE,
        DONE
    } state_t;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic                  eol;
        logic                  last;
    } cmd_t;

endpackage

// File: rtl/dma_2d_burst_calc.sv
// Combinational burst sizing: min(beats left, max burst, room to next 4 KB) plus
// end-of-row / end-of-frame flags for the burst being sized.
module dma_2d_burst_calc
    import dma_2d_pkg::*;
#(
    parameter int C_M_AXI_BURST_LEN = 64,
    parameter int C_IMG_DIM_WIDTH   = 32
) (
    input  logic [C_IMG_DIM_WIDTH-1:0] beats_left_i,
    input  logic [11:0]                addr_lo_i,
    input  logic [C_IMG_DIM_WIDTH-1:0] row_i,
    input  logic [C_IMG_DIM_WIDTH-1:0] height_i,
    output logic [8:0]                 beats_o,
    output logic [AXI_LEN_W-1:0]       len_o,
    output logic                       eol_o,
    output logic                       last_o
);

    logic [10:0] beats_to_4k;
    logic [10:0] cap;

    // NOTE: every variable gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        beats_to_4k = 11'((BOUNDARY_4K - int'(addr_lo_i)) / BYTES_PER_BEAT);
        cap         = (beats_to_4k < 11'(C_M_AXI_BURST_LEN)) ? beats_to_4k : 11'(C_M_AXI_BURST_LEN);
        // A misaligned address in the final word before 4 KB leaves no whole beat; move one so the row advances.
        if (cap == 11'd0) begin
            cap = 11'd1;
        end
        if (beats_left_i < C_IMG_DIM_WIDTH'(cap)) begin
            beats_o = beats_left_i[8:0];
        end else begin
            beats_o = cap[8:0];
        end
        len_o  = AXI_LEN_W'(beats_o - 9'd1);
        eol_o  = (beats_left_i == C_IMG_DIM_WIDTH'(beats_o));
        last_o = eol_o && (row_i == height_i - C_IMG_DIM_WIDTH'(1));
    end

endmodule

// File: rtl/dma_2d_burst_gen.sv
// Per-frame 2D AXI4 INCR burst command generator (rows split at max burst and 4 KB).
// Optional macro DMA_2D_BURST_ALIGN_CHECK_EN adds o_cfg_err for misaligned base/stride.
module dma_2d_burst_gen
    import dma_2d_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_BURST_LEN  = 64,
    parameter int C_IMG_DIM_WIDTH    = 32
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [C_IMG_DIM_WIDTH-1:0]    i_img_width,
    input  logic [C_IMG_DIM_WIDTH-1:0]    i_img_height,
    input  logic [C_IMG_DIM_WIDTH-1:0]    i_img_stride,
    output logic                          o_cmd_valid,
    input  logic                          i_cmd_ready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [AXI_LEN_W-1:0]          o_cmd_len,
    output logic                          o_cmd_eol,
    output logic                          o_cmd_last,
    output logic                          o_busy,
    output logic                          o_done
`ifdef DMA_2D_BURST_ALIGN_CHECK_EN
    ,
    output logic                          o_cfg_err
`endif
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_IMG_DIM_WIDTH;

    // The command struct carries a fixed-width address.
    if (AW != CMD_ADDR_W) begin : g_addr_w_check
        $error("C_M_AXI_ADDR_WIDTH must equal dma_2d_pkg::CMD_ADDR_W");
    end
    if (C_M_AXI_BURST_LEN < 1 || C_M_AXI_BURST_LEN > 256) begin : g_burst_len_check
        $error("C_M_AXI_BURST_LEN must be in 1..256");
    end

    state_t               state_q;
    cmd_t                 cmd_q;
    cmd_t                 cmd_d;
    logic                 valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic [AW-1:0]        row_addr_q;
    logic [AW-1:0]        cur_addr_q;
    logic [AW-1:0]        row_addr_d;
    logic [AW-1:0]        cur_addr_d;
    logic [DW-1:0]        width_q;
    logic [DW-1:0]        height_q;
    logic [DW-1:0]        stride_q;
    logic [DW-1:0]        beats_left_q;
    logic [DW-1:0]        beats_left_d;
    logic [DW-1:0]        row_q;
    logic [8:0]           beats_q;
    logic [8:0]           calc_beats;
    logic [AXI_LEN_W-1:0] calc_len;
    logic                 calc_eol;
    logic                 calc_last;
    logic                 start_empty;
`ifdef DMA_2D_BURST_ALIGN_CHECK_EN
    logic                 cfg_err_q;
    logic                 start_bad;

    assign start_bad = (i_base_addr[1:0] != 2'b00) || (i_img_stride[1:0] != 2'b00);
`endif

    assign start_empty = (i_img_width == '0) || (i_img_height == '0);

    dma_2d_burst_calc #(
        .C_M_AXI_BURST_LEN (C_M_AXI_BURST_LEN),
        .C_IMG_DIM_WIDTH   (C_IMG_DIM_WIDTH)
    ) u_calc (
        .beats_left_i (beats_left_q),
        .addr_lo_i    (cur_addr_q[11:0]),
        .row_i        (row_q),
        .height_i     (height_q),
        .beats_o      (calc_beats),
        .len_o        (calc_len),
        .eol_o        (calc_eol),
        .last_o       (calc_last)
    );

    always_comb begin
        cmd_d        = '{addr: cur_addr_q, len: calc_len, eol: calc_eol, last: calc_last};
        row_addr_d   = row_addr_q + AW'(stride_q);
        cur_addr_d   = cur_addr_q + AW'(beats_q) * AW'(BYTES_PER_BEAT);
        beats_left_d = beats_left_q - DW'(beats_q);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            row_addr_q   <= '0;
            cur_addr_q   <= '0;
            width_q      <= '0;
            height_q     <= '0;
            stride_q     <= '0;
            beats_left_q <= '0;
            row_q        <= '0;
            beats_q      <= '0;
`ifdef DMA_2D_BURST_ALIGN_CHECK_EN
            cfg_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        width_q      <= i_img_width;
                        height_q     <= i_img_height;
                        stride_q     <= i_img_stride;
                        row_addr_q   <= i_base_addr;
                        cur_addr_q   <= i_base_addr;
                        beats_left_q <= i_img_width;
                        row_q        <= '0;
                        busy_q       <= 1'b1;
`ifdef DMA_2D_BURST_ALIGN_CHECK_EN
                        cfg_err_q    <= start_bad;
                        if (start_bad || start_empty) begin
`else
                        if (start_empty) begin
`endif
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    cmd_q   <= cmd_d;
                    beats_q <= calc_beats;
                    valid_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (i_cmd_ready) begin
                        valid_q <= 1'b0;
                        if (cmd_q.last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // Each row restarts from its own base so overlapping strides stay exact.
                            if (cmd_q.eol) begin
                                row_q        <= row_q + DW'(1);
                                row_addr_q   <= row_addr_d;
                                cur_addr_q   <= row_addr_d;
                                beats_left_q <= width_q;
                            end else begin
                                cur_addr_q   <= cur_addr_d;
                                beats_left_q <= beats_left_d;
                            end
                            state_q <= CALC;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_valid = valid_q;
    assign o_cmd_addr  = cmd_q.addr;
    assign o_cmd_len   = cmd_q.len;
    assign o_cmd_eol   = cmd_q.eol;
    assign o_cmd_last  = cmd_q.last;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
`ifdef DMA_2D_BURST_ALIGN_CHECK_EN
    assign o_cfg_err   = cfg_err_q;
`endif

endmodule

// File: tb/tb_dma_2d_burst_gen.sv
// Scoreboard bench for dma_2d_burst_gen: a frame-level model fills an expected
// command queue, and an independent monitor checks every presented command.
module tb_dma_2d_burst_gen;

    localparam int AW = 32;
    localparam int BL = 64;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic          eol;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [DW-1:0] wid = '0;
    logic [DW-1:0] hgt = '0;
    logic [DW-1:0] stride = '0;
    logic          ready = 1'b0;
    logic          o_cmd_valid;
    logic [AW-1:0] o_cmd_addr;
    logic [7:0]    o_cmd_len;
    logic          o_cmd_eol;
    logic          o_cmd_last;
    logic          o_busy;
    logic          o_done;
`ifdef DMA_2D_BURST_ALIGN_CHECK_EN
    logic          o_cfg_err;
`endif

    dma_2d_burst_gen #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_BURST_LEN  (BL),
        .C_IMG_DIM_WIDTH    (DW)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .i_start      (start),
        .i_base_addr  (base),
        .i_img_width  (wid),
        .i_img_height (hgt),
        .i_img_stride (stride),
        .o_cmd_valid  (o_cmd_valid),
        .i_cmd_ready  (ready),
        .o_cmd_addr   (o_cmd_addr),
        .o_cmd_len    (o_cmd_len),
        .o_cmd_eol    (o_cmd_eol),
        .o_cmd_last   (o_cmd_last),
        .o_busy       (o_busy),
        .o_done       (o_done)
`ifdef DMA_2D_BURST_ALIGN_CHECK_EN
        ,
        .o_cfg_err    (o_cfg_err)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Shared bookkeeping: driver writes the first group, monitor the second.
    int   frame_id = 0;
    int   start_cyc = 0;
    int   stall_lo = -1;
    int   stall_hi = -1;
    bit   rand_ready = 1'b0;

    int   mon_frame = -1;
    int   mon_hs_frame = -1;
    int   first_valid_cyc = 0;
    int   first_hs_cyc = 0;
    int   last_hs_cyc = 0;
    int   last_fin_cyc = 0;
    int   done_cyc = 0;
    int   done_cnt = 0;
    int   eol_cnt = 0;
    bit   cfg_err_at_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: walk each row from base + r*stride in bursts limited by
    // the remaining beats, the maximum burst and the distance to the next 4 KB.
    task automatic model_frame(input logic [AW-1:0] b, input int unsigned wd, input int unsigned ht,
                               input logic [AW-1:0] st);
        for (int unsigned r = 0; r < ht; r++) begin
            logic [AW-1:0] a;
            int unsigned   rem;
            a   = b + AW'(r) * st;
            rem = wd;
            while (rem > 0) begin
                int unsigned to4k;
                int unsigned n;
                exp_t        e;
                to4k = (4096 - int'(a % 4096)) / 4;
                n    = rem;
                if (n > BL) n = BL;
                if (n > to4k) n = to4k;
                rem  = rem - n;
                e.addr = a;
                e.len  = 8'(n - 1);
                e.eol  = (rem == 0);
                e.last = (rem == 0) && (r == ht - 1);
                q.push_back(e);
                a = a + AW'(n * 4);
            end
        end
    endtask

    // Ready generator: optional random back-pressure plus a forced-low window.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc >= stall_lo && cyc <= stall_hi) ready = 1'b0;
            else if (rand_ready) ready = 1'($urandom_range(0, 1));
            else ready = 1'b1;
        end
    end

    // Monitor: compares every presented command with the head of the queue.
    initial begin
        bit   prev_valid;
        bit   prev_stall;
        exp_t e;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (o_cmd_valid && !prev_valid) begin
                    if (mon_frame != frame_id) begin
                        mon_frame       = frame_id;
                        first_valid_cyc = cyc;
                    end else begin
                        check("valid_relaunch_latency", 64'(cyc), 64'(last_hs_cyc + 2));
                    end
                end
                if (prev_stall) check("valid_held_under_stall", 64'(o_cmd_valid), 64'd1);
                if (o_cmd_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_cmd_queue_size", 64'(q.size()), 64'd1);
                    end else begin
                        e = q[0];
                        check("cmd", 64'({o_cmd_addr, o_cmd_len, o_cmd_eol, o_cmd_last}), 64'(e));
                        if (ready) begin
                            void'(q.pop_front());
                            if (mon_hs_frame != frame_id) begin
                                mon_hs_frame = frame_id;
                                first_hs_cyc = cyc;
                            end
                            last_hs_cyc = cyc;
                            if (o_cmd_eol) eol_cnt++;
                            if (o_cmd_last) last_fin_cyc = cyc;
                        end
                    end
                end
                if (o_done) begin
                    done_cnt++;
                    done_cyc = cyc;
`ifdef DMA_2D_BURST_ALIGN_CHECK_EN
                    cfg_err_at_done = o_cfg_err;
`endif
                end
                prev_stall = o_cmd_valid && !ready;
                prev_valid = o_cmd_valid;
            end
        end
    end

    task automatic pulse_start(input logic [AW-1:0] b, input int unsigned wd, input int unsigned ht,
                               input logic [AW-1:0] st, input bit stall);
        @(posedge clk);
        #1;
        base      = b;
        wid       = wd;
        hgt       = ht;
        stride    = st;
        start     = 1'b1;
        start_cyc = cyc;
        frame_id++;
        if (stall) begin
            stall_lo = cyc + 2;
            stall_hi = cyc + 6;
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        base   = $urandom;
        wid    = $urandom;
        hgt    = $urandom;
        stride = $urandom;
    endtask

    task automatic wait_done(input int done0);
        int k;
        k = 0;
        while (done_cnt == done0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 64'(done_cnt != done0), 64'd1);
    endtask

    task automatic run_frame(input logic [AW-1:0] b, input int unsigned wd, input int unsigned ht,
                             input logic [AW-1:0] st, input bit stall, input bit second_start);
        int ncmd;
        int done0;
        ncmd  = q.size();
        model_frame(b, wd, ht, st);
        ncmd  = q.size() - ncmd;
        done0 = done_cnt;
        pulse_start(b, wd, ht, st, stall);
        check("busy_after_start", 64'(o_busy), 64'd1);
        if (second_start) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(done0);
        if (ncmd == 0) begin
            check("done_latency_empty", 64'(done_cyc), 64'(start_cyc + 1));
        end else begin
            check("done_latency", 64'(done_cyc), 64'(last_fin_cyc + 1));
            check("first_valid_latency", 64'(first_valid_cyc), 64'(start_cyc + 2));
        end
        if (stall) check("stalled_accept_cycle", 64'(first_hs_cyc), 64'(start_cyc + 7));
        @(negedge clk);
        @(negedge clk);
        check("done_one_cycle", 64'(done_cnt), 64'(done0 + 1));
        check("idle_not_busy", 64'(o_busy), 64'd0);
        check("queue_drained", 64'(q.size()), 64'd0);
        stall_lo = -1;
        stall_hi = -1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({o_cmd_valid, o_cmd_addr, o_cmd_len, o_cmd_eol, o_cmd_last, o_busy, o_done}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_frame(32'h1000_0000, 16, 2, 32'd64, 1'b0, 1'b0);
        run_frame(32'h0000_0000, 100, 1, 32'd0, 1'b0, 1'b0);
        run_frame(32'h0000_0FF0, 8, 1, 32'd0, 1'b0, 1'b0);
        run_frame(32'h0000_2000, 40, 2, 32'd256, 1'b1, 1'b1);
        run_frame(32'h0000_3000, 0, 5, 32'd64, 1'b0, 1'b0);
        run_frame(32'h0000_3000, 7, 0, 32'd64, 1'b0, 1'b0);
        run_frame(32'h0000_5000, 20, 3, 32'd40, 1'b0, 1'b0);
        run_frame(32'hFFFF_FFC0, 40, 2, 32'd128, 1'b0, 1'b0);

        // Reset during row 1 of a 3-row frame, then a fresh frame.
        begin
            int e0;
            int k;
            model_frame(32'h0000_4000, 80, 3, 32'd512);
            e0 = eol_cnt;
            pulse_start(32'h0000_4000, 80, 3, 32'd512, 1'b0);
            k = 0;
            while (eol_cnt < e0 + 1 && k < 5000) begin
                @(negedge clk);
                k++;
            end
            check("reached_row1", 64'(eol_cnt >= e0 + 1), 64'd1);
            @(posedge clk);
            #1;
            rst = 1'b1;
            q.delete();
            @(posedge clk);
            @(negedge clk);
            check("reset_midframe_valid", 64'(o_cmd_valid), 64'd0);
            check("reset_midframe_busy", 64'(o_busy), 64'd0);
            check("reset_midframe_done", 64'(o_done), 64'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        run_frame(32'h0000_8000, 24, 2, 32'd96, 1'b0, 1'b0);

`ifdef DMA_2D_BURST_ALIGN_CHECK_EN
        begin
            int done0;
            done0 = done_cnt;
            pulse_start(32'h0000_1002, 16, 2, 32'd64, 1'b0);
            wait_done(done0);
            check("cfg_err_done_latency", 64'(done_cyc), 64'(start_cyc + 1));
            check("cfg_err_with_done", 64'(cfg_err_at_done), 64'd1);
            repeat (3) @(negedge clk);
            check("cfg_err_held", 64'(o_cfg_err), 64'd1);
            done0 = done_cnt;
            pulse_start(32'h0000_1000, 16, 2, 32'd66, 1'b0);
            wait_done(done0);
            check("cfg_err_stride", 64'(cfg_err_at_done), 64'd1);
            run_frame(32'h0000_1000, 16, 1, 32'd64, 1'b0, 1'b0);
            check("cfg_err_cleared", 64'(o_cfg_err), 64'd0);
        end
`endif

        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            logic [AW-1:0] b;
            logic [AW-1:0] st;
            int unsigned   wd;
            int unsigned   ht;
            b  = (i % 5 == 4) ? (32'hFFFF_F000 | ($urandom & 32'h0000_0FFC)) : ($urandom & 32'hFFFF_FFFC);
            st = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : AW'($urandom_range(0, 3072) * 4);
            wd = $urandom_range(1, 300);
            ht = $urandom_range(1, 4);
            run_frame(b, wd, ht, st, 1'b0, 1'b0);
        end
        rand_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
